// File: rtl/vreg_file_masked.sv
// Vector register file: NREGS x (LANES x LANE_W), NRD combinational read ports, one
// lane-masked write port with same-cycle bypass, dirty flags and a sequential bulk clear.
module vreg_file_masked #(
  parameter  int NREGS  = 8,
  parameter  int LANES  = 8,
  parameter  int LANE_W = 32,
  parameter  int NRD    = 2,
  localparam int AW     = $clog2(NREGS),
  localparam int VW     = LANES * LANE_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NRD*AW-1:0] ra,
  output logic [NRD*VW-1:0] rd,
  input  logic              we,
  input  logic [AW-1:0]     wa,
  input  logic [VW-1:0]     wd,
  input  logic [LANES-1:0]  wmask,
  output logic              wr_ready,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done,
  output logic [NREGS-1:0]  dirty
);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t        state;
  logic [AW-1:0] cnt;
  logic [VW-1:0] rf [NREGS];
  logic          wr_en;

  assign wr_ready = (state == IDLE);
  assign clr_busy = (state == CLEAR);
  assign wr_en    = we && wr_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NREGS; r++) rf[r] <= '0;
      dirty    <= '0;
      state    <= IDLE;
      cnt      <= '0;
      clr_done <= 1'b0;
    end else begin
      clr_done <= 1'b0;
      case (state)
        IDLE: begin
          // A write coinciding with clr_req still lands; the clear wipes it later.
          if (wr_en) begin
            for (int l = 0; l < LANES; l++)
              if (wmask[l]) rf[wa][l*LANE_W +: LANE_W] <= wd[l*LANE_W +: LANE_W];
            if (|wmask) dirty[wa] <= 1'b1;
          end
          if (clr_req) begin
            state <= CLEAR;
            cnt   <= '0;
          end
        end
        CLEAR: begin
          rf[cnt]    <= '0;
          dirty[cnt] <= 1'b0;
          cnt        <= cnt + 1'b1;
          if (cnt == AW'(NREGS - 1)) begin
            state    <= IDLE;
            clr_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Each read port resolves the write bypass lane by lane, independently.
  generate
    for (genvar gi = 0; gi < NRD; gi++) begin : g_port
      logic [AW-1:0] ra_p;
      logic          hit;
      assign ra_p = ra[gi*AW +: AW];
      assign hit  = wr_en && (wa == ra_p);
      for (genvar gj = 0; gj < LANES; gj++) begin : g_lane
        assign rd[gi*VW + gj*LANE_W +: LANE_W] =
          (hit && wmask[gj]) ? wd[gj*LANE_W +: LANE_W] : rf[ra_p][gj*LANE_W +: LANE_W];
      end
    end
  endgenerate

endmodule

// File: tb/tb_vreg_file_masked.sv
// Randomised bench for vreg_file_masked: lane-array reference model compared every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_vreg_file_masked;
  localparam int NREGS  = 8;
  localparam int LANES  = 8;
  localparam int LANE_W = 32;
  localparam int NRD    = 2;
  localparam int AW     = $clog2(NREGS);
  localparam int VW     = LANES * LANE_W;

  logic              clk = 1'b0;
  logic              reset;
  logic [NRD*AW-1:0] ra;
  logic [NRD*VW-1:0] rd;
  logic              we;
  logic [AW-1:0]     wa;
  logic [VW-1:0]     wd;
  logic [LANES-1:0]  wmask;
  logic              wr_ready, clr_req, clr_busy, clr_done;
  logic [NREGS-1:0]  dirty;

  vreg_file_masked #(.NREGS(NREGS), .LANES(LANES), .LANE_W(LANE_W), .NRD(NRD)) dut (
    .clk(clk), .reset(reset), .ra(ra), .rd(rd), .we(we), .wa(wa), .wd(wd),
    .wmask(wmask), .wr_ready(wr_ready), .clr_req(clr_req), .clr_busy(clr_busy),
    .clr_done(clr_done), .dirty(dirty)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain lane arrays, a dirty bit per register, and the number
  // of registers still waiting to be cleared (0 = not clearing).
  logic [LANE_W-1:0] mem [NREGS][LANES];
  bit                mdirty [NREGS];
  int                clr_left;
  bit                mdone;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NREGS; r++) begin
        for (int l = 0; l < LANES; l++) mem[r][l] <= '0;
        mdirty[r] <= 1'b0;
      end
      clr_left <= 0;
      mdone    <= 1'b0;
    end else begin
      mdone <= 1'b0;
      if (clr_left == 0) begin
        if (we) begin
          for (int l = 0; l < LANES; l++)
            if (wmask[l]) mem[wa][l] <= wd[l*LANE_W +: LANE_W];
          if (wmask != 0) mdirty[wa] <= 1'b1;
        end
        if (clr_req) clr_left <= NREGS;
      end else begin
        for (int l = 0; l < LANES; l++) mem[NREGS - clr_left][l] <= '0;
        mdirty[NREGS - clr_left] <= 1'b0;
        clr_left <= clr_left - 1;
        if (clr_left == 1) mdone <= 1'b1;
      end
    end
  end

  function automatic logic [VW-1:0] model_read(input int a);
    logic [VW-1:0] v;
    for (int l = 0; l < LANES; l++)
      v[l*LANE_W +: LANE_W] = (clr_left == 0 && we && wa == a && wmask[l])
                              ? wd[l*LANE_W +: LANE_W] : mem[a][l];
    return v;
  endfunction

  // Per-cycle compare process.
  always @(negedge clk) begin
    logic [NREGS-1:0] dexp;
    for (int r = 0; r < NREGS; r++) dexp[r] = mdirty[r];
    for (int p = 0; p < NRD; p++)
      chk($sformatf("rd%0d", p), rd[p*VW +: VW], model_read(int'(ra[p*AW +: AW])));
    chk("wr_ready", VW'(wr_ready), VW'(clr_left == 0));
    chk("clr_busy", VW'(clr_busy), VW'(clr_left != 0));
    chk("clr_done", VW'(clr_done), VW'(mdone));
    chk("dirty", VW'(dirty), VW'(dexp));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ra(input int a0, input int a1);
    ra[0 +: AW]  = AW'(a0);
    ra[AW +: AW] = AW'(a1);
  endtask

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] v;
    for (int l = 0; l < LANES; l++) v[l*LANE_W +: LANE_W] = $urandom;
    return v;
  endfunction

  task automatic fill_all();
    we = 1; wmask = '1;
    for (int r = 0; r < NREGS; r++) begin
      wa = AW'(r); wd = rand_vec();
      tick();
    end
    we = 0;
  endtask

  logic [VW-1:0] exp_v;
  int busy_cnt, done_cnt;

  initial begin
    reset = 0; we = 0; wa = '0; wd = '0; wmask = '0; clr_req = 0; ra = '0;
    repeat (3) tick();
    reset = 1;
    tick();

    // Reset contents on both ports
    for (int r = 0; r < NREGS; r++) begin
      set_ra(r, NREGS - 1 - r);
      @(negedge clk);
      chk("reset_rd0", rd[0 +: VW], '0);
      chk("reset_rd1", rd[VW +: VW], '0);
      tick();
    end
    chk("reset_ready", VW'(wr_ready), VW'(1));

    // Masked write then partial overwrite of reg 3
    we = 1; wa = 3; wmask = 8'hFF;
    for (int l = 0; l < LANES; l++) wd[l*LANE_W +: LANE_W] = LANE_W'(l + 1);
    tick();
    wmask = 8'h0F; wd = {LANES{32'hAAAA_AAAA}};
    tick();
    we = 0; set_ra(3, 3);
    @(negedge clk);
    for (int l = 0; l < LANES; l++)
      exp_v[l*LANE_W +: LANE_W] = (l < 4) ? 32'hAAAA_AAAA : LANE_W'(l + 1);
    chk("masked_rf3", rd[0 +: VW], exp_v);
    chk("dirty_08", VW'(dirty), VW'(8'h08));
    tick();

    // Same-cycle bypass on both ports
    we = 1; wa = 2; wmask = 8'h81; wd = {LANES{32'h0000_1234}}; set_ra(2, 2);
    @(negedge clk);
    exp_v = '0;
    exp_v[0 +: LANE_W] = 32'h1234;
    exp_v[7*LANE_W +: LANE_W] = 32'h1234;
    chk("bypass_p0", rd[0 +: VW], exp_v);
    chk("bypass_p1", rd[VW +: VW], exp_v);
    tick();
    wa = 4; wmask = 8'h00;
    tick();
    we = 0;
    @(negedge clk);
    chk("dirty_mask0", VW'(dirty), VW'(8'h0C));
    tick();

    // Full bulk clear with writes attempted while busy
    fill_all();
    clr_req = 1;
    tick();
    clr_req = 0; we = 1; wa = 0; wmask = '1; wd = rand_vec(); set_ra(0, NREGS - 1);
    busy_cnt = 0; done_cnt = 0;
    for (int i = 0; i < NREGS; i++) begin
      @(negedge clk);
      busy_cnt += int'(clr_busy);
      done_cnt += int'(clr_done);
      if (wr_ready) chk("ready_in_busy", VW'(wr_ready), VW'(0));
      tick();
    end
    we = 0;
    @(negedge clk);
    chk("busy_cycles", VW'(busy_cnt), VW'(NREGS));
    chk("done_pulse", VW'(clr_done), VW'(1));
    chk("done_early", VW'(done_cnt), VW'(0));
    chk("dropped_wr", rd[0 +: VW], '0);
    chk("dirty_clr", VW'(dirty), '0);
    tick();
    @(negedge clk);
    chk("done_single", VW'(clr_done), VW'(0));

    // Write coinciding with clr_req lands, then is wiped
    we = 1; wa = 5; wmask = '1; wd = rand_vec(); exp_v = wd; clr_req = 1;
    tick();
    we = 0; clr_req = 0; set_ra(5, 5);
    @(negedge clk);
    chk("wr_with_clr", rd[0 +: VW], exp_v);
    repeat (NREGS) tick();
    @(negedge clk);
    chk("wr_wiped", rd[0 +: VW], '0);
    tick();

    // Reset during clear cycle 4: abort, no done pulse
    fill_all();
    clr_req = 1;
    tick();
    clr_req = 0;
    repeat (3) tick();
    reset = 0;
    @(negedge clk);
    chk("abort_busy", VW'(clr_busy), '0);
    tick();
    reset = 1;
    done_cnt = 0;
    for (int i = 0; i < 2 * NREGS; i++) begin
      @(negedge clk);
      done_cnt += int'(clr_done);
      tick();
    end
    chk("abort_no_done", VW'(done_cnt), '0);

    // Random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      we = ($urandom_range(0, 3) != 0);
      wa = AW'($urandom);
      wd = rand_vec();
      wmask = LANES'($urandom);
      if ($urandom_range(0, 7) == 0) wmask = '1;
      clr_req = ($urandom_range(0, 39) == 0);
      set_ra($urandom_range(0, NREGS - 1), ($urandom_range(0, 2) == 0) ? int'(wa) : $urandom_range(0, NREGS - 1));
      tick();
    end
    we = 0; clr_req = 0;
    repeat (NREGS + 2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
